// File: rtl/microc_pkg.sv
// Shared opcode encodings, ALU constants and run-control state type for the
// microcontroller control unit.
package microc_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_JZ   = 6'b000010;
    localparam logic [5:0] OP_JNZ  = 6'b000011;
    localparam logic [5:0] OP_HALT = 6'b001111;

    localparam int         OPC_ALU_MSB   = 5;
    localparam logic [3:0] OPC_LI_PREFIX = 4'b0100;

    localparam logic [2:0] ALU_PASS_A = 3'b000;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_HALT,
        S_STEP
    } state_e;

endpackage

// File: rtl/microc_ctrl_if.sv
// Control-unit bundle: datapath/debug inputs and decoded control outputs.
// master = datapath/debugger side, slave = control unit.
interface microc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             z;
    logic             dbg_run;
    logic             dbg_halt;
    logic             dbg_step;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic             wez;
    logic [2:0]       Op;
    logic             pc_we;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output opcode, z, dbg_run, dbg_halt, dbg_step,
        input  s_inc, s_inm, we3, wez, Op, pc_we, halted, illegal, instr_count
    );

    modport slave (
        input  opcode, z, dbg_run, dbg_halt, dbg_step,
        output s_inc, s_inm, we3, wez, Op, pc_we, halted, illegal, instr_count
    );
endinterface

// File: rtl/microc_decode.sv
// Purely combinational instruction decoder: opcode and zero flag to datapath
// selects, write enables, HALT detection and reserved-opcode indication.
module microc_decode
    import microc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic       z_i,
    output logic       s_inc_o,
    output logic       s_inm_o,
    output logic       we3_o,
    output logic       wez_o,
    output logic [2:0] op_o,
    output logic       halt_o,
    output logic       illegal_o
);

    always_comb begin
        s_inc_o   = 1'b0;
        s_inm_o   = 1'b0;
        we3_o     = 1'b0;
        wez_o     = 1'b0;
        op_o      = ALU_PASS_A;
        halt_o    = 1'b0;
        illegal_o = 1'b0;
        if (opcode_i[OPC_ALU_MSB]) begin
            op_o  = opcode_i[4:2];
            we3_o = 1'b1;
            wez_o = 1'b1;
        end else if (opcode_i[5:2] == OPC_LI_PREFIX) begin
            op_o    = ALU_PASS_A;
            s_inm_o = 1'b1;
            we3_o   = 1'b1;
        end else begin
            case (opcode_i)
                OP_NOP:  ;
                OP_J:    s_inc_o = 1'b1;
                OP_JZ:   s_inc_o = z_i;
                OP_JNZ:  s_inc_o = ~z_i;
                OP_HALT: halt_o  = 1'b1;
                // Reserved encodings fall through as NOP with a flag.
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/microc_ctrl.sv
// Control unit top: run/halt/single-step sequencer, execute-cycle gating of the
// decoder outputs, and the retired-instruction counter.
module microc_ctrl
    import microc_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int RESUME_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset,
    microc_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exec;

    logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_halt, dec_illegal;
    logic [2:0] dec_op;

    microc_decode u_decode (
        .opcode_i  (bus.opcode),
        .z_i       (bus.z),
        .s_inc_o   (dec_s_inc),
        .s_inm_o   (dec_s_inm),
        .we3_o     (dec_we3),
        .wez_o     (dec_wez),
        .op_o      (dec_op),
        .halt_o    (dec_halt),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset suppresses execution in its own cycle so nothing is written mid-step.
    always_comb begin
        state_d = state_q;
        exec    = 1'b0;
        case (state_q)
            S_INIT: state_d = (RESUME_ON_RESET != 0) ? S_RUN : S_HALT;
            S_RUN: begin
                exec = ~reset;
                if (bus.dbg_halt || dec_halt) state_d = S_HALT;
            end
            S_HALT: begin
                if (bus.dbg_halt)      state_d = S_HALT;
                else if (bus.dbg_run)  state_d = S_RUN;
                else if (bus.dbg_step) state_d = S_STEP;
            end
            S_STEP: begin
                exec    = ~reset;
                state_d = S_HALT;
            end
            default: state_d = S_INIT;
        endcase
        cnt_d = exec ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    always_comb begin
        bus.pc_we   = 1'b0;
        bus.s_inc   = 1'b0;
        bus.s_inm   = 1'b0;
        bus.we3     = 1'b0;
        bus.wez     = 1'b0;
        bus.Op      = 3'b000;
        bus.illegal = 1'b0;
        if (exec) begin
            bus.pc_we   = 1'b1;
            bus.s_inc   = dec_s_inc;
            bus.s_inm   = dec_s_inm;
            bus.we3     = dec_we3;
            bus.wez     = dec_wez;
            bus.Op      = dec_op;
            bus.illegal = dec_illegal;
        end
    end

    assign bus.halted      = (state_q == S_HALT);
    assign bus.instr_count = cnt_q;

endmodule

// File: doc/microc_ctrl.md
Name: microc_ctrl

Overview:
Control unit and run-control sequencer for the single-cycle 8-bit microcontroller datapath (10-bit PC, 16-bit instruction word, 16x8 register file, 3-bit-op ALU, zero flag).
- Decodes the 6-bit opcode (instr[15:10]) and the registered zero flag into the datapath selects and write enables.
- Adds a run/halt/single-step FSM, a HALT instruction, an illegal-opcode indication and a retired-instruction counter.
- The datapath PC register gains a write enable driven by pc_we; it holds its value when pc_we=0.

Parameters:
CNT_W, 16, width of the retired-instruction counter
RESUME_ON_RESET, 1, 1: leave S_INIT to S_RUN; 0: leave S_INIT to S_HALT

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
opcode  in  6  instr[15:10] from the datapath
z  in  1  registered zero flag from the datapath
dbg_run  in  1  single-cycle request: HALT to RUN
dbg_halt  in  1  single-cycle request: RUN to HALT
dbg_step  in  1  single-cycle request: execute exactly one instruction while halted
s_inc  out  1  PC mux select: 0 = PC+1, 1 = jump target instr[9:0]
s_inm  out  1  1 = immediate instr[7:0] on ALU A input, WA3 drives RA2
we3  out  1  register-file write enable
wez  out  1  zero-flag write enable
Op  out  3  ALU operation
pc_we  out  1  PC register write enable
halted  out  1  1 while in S_HALT
illegal  out  1  one-cycle pulse when an executed opcode is reserved
instr_count  out  CNT_W  number of retired instructions

Behaviour:
Decode table, combinational, applied only in an execute cycle:
- 1ooo xx (ALU reg-reg): Op=opcode[4:2], s_inm=0, we3=1, wez=1, s_inc=0.
- 0100 xx (LI): Op=ALU_PASS_A (3'b000), s_inm=1, we3=1, wez=0, s_inc=0.
- 000000 (NOP): all enables 0, s_inc=0.
- 000001 (J): s_inc=1.
- 000010 (JZ): s_inc=z.
- 000011 (JNZ): s_inc=~z.
- 001111 (HALT): enables 0, s_inc=0.
- Any other opcode: executes as NOP and sets illegal=1 for that cycle.

Execute cycle:
- An execute cycle is state S_RUN, or state S_STEP.
- In an execute cycle: pc_we=1 and the decoded enables are driven.
- In every non-execute cycle: pc_we=0, we3=0, wez=0, s_inc=0, s_inm=0, Op=0, illegal=0.

States: S_INIT, S_RUN, S_HALT, S_STEP.
- reset=1: next state S_INIT, instr_count=0. Reset takes effect at any point, including mid-step.
- S_INIT: lasts 1 cycle, non-execute. Next state is S_RUN if RESUME_ON_RESET=1, else S_HALT.
- S_RUN: executes the current instruction.
  - Next state S_HALT if dbg_halt=1 or opcode=HALT.
  - Otherwise stays in S_RUN.
  - The instruction in the cycle that sees dbg_halt still executes; the halt takes effect from the next cycle.
- S_HALT: non-execute, halted=1.
  - dbg_halt has priority over dbg_run.
  - dbg_run=1 moves to S_RUN.
  - Otherwise dbg_step=1 moves to S_STEP.
  - Otherwise stays in S_HALT.
- S_STEP: exactly one execute cycle, then S_HALT unconditionally. dbg_* inputs are ignored in S_STEP.

HALT instruction:
- Executes with pc_we=1 and PC+1, so the PC points past it.
- A following dbg_run continues at the next instruction and does not re-halt.

instr_count:
- Increments by 1 on every execute cycle, including NOP, jumps, illegal and HALT.
- Wraps modulo 2^CNT_W.

Reset values: halted=0 (the state is S_INIT), all enables 0, instr_count=0.
Latency:
- Decode-to-enable is 0 cycles (single-cycle datapath).
- dbg_* requests act on the following cycle.

Decomposition:
Package microc_pkg holds:
- opcode constants: OP_NOP, OP_J, OP_JZ, OP_JNZ, OP_HALT, OPC_ALU_MSB, OPC_LI_PREFIX;
- ALU_PASS_A;
- the state enum.

Sub-module microc_decode, purely combinational: opcode, z to enables and illegal. The FSM and counter stay in microc_ctrl, which gates the decode outputs with the execute-cycle signal.

Test Plan:
1. Reset held 2 cycles, RESUME_ON_RESET=1, then opcode=100100 (ALU, Op=001) -> 1 idle S_INIT cycle with pc_we=0; next cycle pc_we=1, we3=1, wez=1, Op=3'b001, instr_count=1.
2. In S_RUN: opcode=000010 with z=1, then z=0 -> s_inc=1, then s_inc=0; opcode=000011 with z=0 -> s_inc=1; opcode=010000 -> s_inm=1, we3=1, wez=0, Op=000.
3. opcode=001111 in S_RUN -> that cycle pc_we=1, s_inc=0, count+1; next cycle halted=1, pc_we=0. dbg_run pulse -> S_RUN the cycle after.
4. Halted with opcode=100000: dbg_step pulse -> exactly one cycle with pc_we=1, we3=1; then halted=1 again, instr_count +1 only.
5. dbg_halt and dbg_run both high in S_HALT -> remains halted. opcode=000111 in S_RUN -> illegal=1 for one cycle, we3=0, pc_we=1.
6. Preload instr_count=2^CNT_W-1 by running, execute one instruction -> instr_count=0. Assert reset during S_STEP -> S_INIT, instr_count=0, no write enable in the reset cycle.
